// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with start/busy/done handshake, optional signed input, overflow and blanking mask.
module bcd_converter_seq #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5,
  parameter int SIGNED    = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic                  overflow,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int WW = 4 * DIGITS;
  localparam int CW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_nxt;
  logic [BIN_WIDTH-1:0] mag, mag_in;
  logic [WW-1:0]        work, work_adj, work_nxt;
  logic [CW-1:0]        cnt;
  logic                 sign_q, sign_in, ovf_q, drop, accept, last_bit, acc;
  logic [DIGITS-1:0]    en_nxt;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (cnt == LAST);
  assign sign_in  = (SIGNED != 0) && bin[BIN_WIDTH-1];
  assign mag_in   = sign_in ? (~bin + 1'b1) : bin;
  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);

  // One double-dabble step: add 3 to digits above 4, then shift in the next magnitude bit.
  always_comb begin
    work_adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] > 4'd4)
        work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
    drop     = work_adj[WW-1];
    work_nxt = {work_adj[WW-2:0], mag[BIN_WIDTH-1]};
  end

  always_comb begin
    en_nxt = '0;
    acc    = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc       = acc | (|work_nxt[4*i +: 4]);
      en_nxt[i] = acc;
    end
    en_nxt[0] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Visible outputs only change on the edge that finishes the last bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mag      <= '0;
      work     <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      bcd      <= '0;
      negative <= 1'b0;
      overflow <= 1'b0;
      digit_en <= DIGITS'(1);
    end else if (accept) begin
      mag    <= mag_in;
      sign_q <= sign_in;
      work   <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else if (state == SHIFT) begin
      mag   <= mag << 1;
      work  <= work_nxt;
      cnt   <= cnt + CW'(1);
      ovf_q <= ovf_q | drop;
      if (last_bit) begin
        bcd      <= work_nxt;
        negative <= sign_q;
        overflow <= ovf_q | drop;
        digit_en <= en_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Scoreboard bench for bcd_converter_seq: three configurations (16/5 unsigned,
// 8/2 unsigned, 8/3 signed) checked against an arithmetic decimal model.
module tb_bcd_converter_seq;

  typedef struct {
    int          sel;
    int          due;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic        neg;
    logic        ovf;
    logic [7:0]  en;
  } rec_t;

  localparam int BWS [3] = '{16, 8, 8};
  localparam int DGS [3] = '{5, 2, 3};
  localparam int SGS [3] = '{0, 0, 1};

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start0, start1, start2;
  logic [15:0] bin0;
  logic [7:0]  bin1, bin2;
  logic        busy0, busy1, busy2, done0, done1, done2;
  logic [19:0] bcd0;
  logic [7:0]  bcd1;
  logic [11:0] bcd2;
  logic        neg0, neg1, neg2, ovf0, ovf1, ovf2;
  logic [4:0]  en0;
  logic [1:0]  en1;
  logic [2:0]  en2;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;
  rec_t scb [$];
  rec_t last_r [3];

  bcd_converter_seq #(.BIN_WIDTH(16), .DIGITS(5), .SIGNED(0)) u_w16 (
    .clock(clock), .reset_n(reset_n), .start(start0), .bin(bin0), .busy(busy0),
    .done(done0), .bcd(bcd0), .negative(neg0), .overflow(ovf0), .digit_en(en0));
  bcd_converter_seq #(.BIN_WIDTH(8), .DIGITS(2), .SIGNED(0)) u_w8 (
    .clock(clock), .reset_n(reset_n), .start(start1), .bin(bin1), .busy(busy1),
    .done(done1), .bcd(bcd1), .negative(neg1), .overflow(ovf1), .digit_en(en1));
  bcd_converter_seq #(.BIN_WIDTH(8), .DIGITS(3), .SIGNED(1)) u_s8 (
    .clock(clock), .reset_n(reset_n), .start(start2), .bin(bin2), .busy(busy2),
    .done(done2), .bcd(bcd2), .negative(neg2), .overflow(ovf2), .digit_en(en2));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Decimal reference: plain division/modulo on the magnitude.
  function automatic rec_t model(int s, logic [15:0] v);
    rec_t   r;
    longint val, mag, lim, low, p;
    int     w = BWS[s];
    int     d = DGS[s];
    val   = longint'(v) & ((longint'(1) << w) - 1);
    r.sel = s;  r.due = 0;  r.busy = 1'b0;  r.done = 1'b1;
    r.neg = (SGS[s] != 0) && (((val >> (w - 1)) & 1) == 1);
    mag   = r.neg ? ((longint'(1) << w) - val) : val;
    lim   = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    r.ovf = (mag >= lim);
    low   = mag % lim;
    r.bcd = '0;
    p     = low;
    for (int i = 0; i < d; i++) begin
      r.bcd[4*i +: 4] = 4'(p % 10);
      p = p / 10;
    end
    r.en = '0;
    p    = 1;
    for (int i = 0; i < d; i++) begin
      r.en[i] = (i == 0) || ((low / p) != 0);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic rec_t reset_rec(int s);
    rec_t r;
    r.sel = s;  r.due = 0;  r.busy = 1'b0;  r.done = 1'b0;
    r.bcd = '0; r.neg = 1'b0; r.ovf = 1'b0; r.en = 8'd1;
    return r;
  endfunction

  function automatic rec_t sample(int s);
    rec_t r;
    r = reset_rec(s);
    case (s)
      0: begin r.busy = busy0; r.done = done0; r.bcd = 32'(bcd0); r.neg = neg0; r.ovf = ovf0; r.en = 8'(en0); end
      1: begin r.busy = busy1; r.done = done1; r.bcd = 32'(bcd1); r.neg = neg1; r.ovf = ovf1; r.en = 8'(en1); end
      default: begin r.busy = busy2; r.done = done2; r.bcd = 32'(bcd2); r.neg = neg2; r.ovf = ovf2; r.en = 8'(en2); end
    endcase
    return r;
  endfunction

  task automatic drive(int s, logic st, logic [15:0] v);
    case (s)
      0:       begin start0 = st; bin0 = v; end
      1:       begin start1 = st; bin1 = v[7:0]; end
      default: begin start2 = st; bin2 = v[7:0]; end
    endcase
  endtask

  task automatic check_rec(string nm, int s, rec_t e);
    rec_t o;
    o = sample(s);
    chk({nm, ".busy"}, 32'(o.busy), 32'(e.busy));
    chk({nm, ".done"}, 32'(o.done), 32'(e.done));
    chk({nm, ".bcd"},  o.bcd, e.bcd);
    chk({nm, ".neg"},  32'(o.neg), 32'(e.neg));
    chk({nm, ".ovf"},  32'(o.ovf), 32'(e.ovf));
    chk({nm, ".en"},   32'(o.en), 32'(e.en));
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic applyStimulus(int s, logic [15:0] v, int gap);
    rec_t e;
    int   n = 0;
    repeat (gap) @(negedge clock);
    while (sample(s).busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("wait_not_busy", 32'(n), 32'd0);
    drive(s, 1'b1, v);
    e     = model(s, v);
    e.due = cyc + 1 + BWS[s];
    scb.push_back(e);
    @(negedge clock);
    drive(s, 1'b0, 16'($urandom));
  endtask

  task automatic poke_busy(int s);
    repeat (3) @(negedge clock);
    chk("poke_while_busy", 32'(sample(s).busy), 32'd1);
    drive(s, 1'b1, 16'($urandom));
    @(negedge clock);
    drive(s, 1'b0, 16'($urandom));
  endtask

  task automatic drain();
    int n = 0;
    while (scb.size() != 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("drain_pending", 32'(scb.size()), 32'd0);
    repeat (4) @(negedge clock);
  endtask

  task automatic run_block(int s, int n_rand);
    for (int i = 0; i < n_rand; i++)
      applyStimulus(s, 16'($urandom), $urandom_range(0, 3));
    drain();
  endtask

  // Monitor: pops on done, and requires stable outputs during a conversion.
  always @(negedge clock) begin
    if (reset_n && mon_en) begin
      for (int s = 0; s < 3; s++) begin
        rec_t o, e;
        o = sample(s);
        if (o.done) begin
          if (scb.size() == 0) begin
            chk("unexpected_done", 32'(s), 32'hFFFF_FFFF);
          end else begin
            e = scb.pop_front();
            chk("result.sel", 32'(s), 32'(e.sel));
            chk("result.latency", 32'(cyc), 32'(e.due));
            chk("result.bcd", o.bcd, e.bcd);
            chk("result.neg", 32'(o.neg), 32'(e.neg));
            chk("result.ovf", 32'(o.ovf), 32'(e.ovf));
            chk("result.en", 32'(o.en), 32'(e.en));
            chk("result.busy", 32'(o.busy), 32'd0);
            last_r[s] = e;
          end
        end else if (o.busy) begin
          chk("hold.bcd", o.bcd, last_r[s].bcd);
          chk("hold.neg", 32'(o.neg), 32'(last_r[s].neg));
          chk("hold.ovf", 32'(o.ovf), 32'(last_r[s].ovf));
          chk("hold.en", 32'(o.en), 32'(last_r[s].en));
        end
      end
    end
  end

  task automatic checkOutput();
    for (int s = 0; s < 3; s++) check_rec("reset", s, reset_rec(s));
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      drive(s, 1'b0, 16'h0);
      last_r[s] = reset_rec(s);
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput();
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clock);

    $display("[TB] 16-bit / 5-digit unsigned");
    applyStimulus(0, 16'hFFFF, 0);
    applyStimulus(0, 16'd0, 2);
    applyStimulus(0, 16'd1234, 0);
    applyStimulus(0, 16'd4321, 1);
    poke_busy(0);
    run_block(0, 20);

    $display("[TB] 8-bit / 2-digit unsigned");
    applyStimulus(1, 16'd255, 0);
    applyStimulus(1, 16'd99, 0);
    applyStimulus(1, 16'd100, 0);
    run_block(1, 15);

    $display("[TB] 8-bit / 3-digit signed");
    applyStimulus(2, 16'h0080, 0);
    applyStimulus(2, 16'h00FF, 0);
    applyStimulus(2, 16'h007F, 0);
    applyStimulus(2, 16'h0000, 0);
    run_block(2, 15);

    $display("[TB] reset during conversion");
    applyStimulus(0, 16'd54321, 0);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_rec("midreset", 0, reset_rec(0));
    scb.delete();
    last_r[0] = reset_rec(0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (25) @(negedge clock);
    applyStimulus(0, 16'd9876, 0);
    applyStimulus(0, 16'd10000, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
